// File: rtl/abae_spi_pkg.sv
// Shared SPI definitions: default frame geometry, frame length helper and the
// receive FSM state type. Shared between spi_frame_rx and spi_controller.
// Configuration macro: SPI_RX_PARITY_EN appends one even-parity bit to each frame.
package abae_spi_pkg;

  localparam int unsigned HEADER_SIZE_DEF  = 32;
  localparam int unsigned MESSAGE_SIZE_DEF = 512;

`ifdef SPI_RX_PARITY_EN
  localparam int unsigned PARITY_BITS = 1;
`else
  localparam int unsigned PARITY_BITS = 0;
`endif

  localparam int unsigned FRAME_BITS = HEADER_SIZE_DEF + MESSAGE_SIZE_DEF + PARITY_BITS;

  typedef enum logic [1:0] {
    StIdle         = 2'd0,
    StShift        = 2'd1,
    StWaitDeselect = 2'd2
  } spi_state_e;

  // Serial frame length for a given header/message geometry.
  function automatic int unsigned frame_bits(int unsigned hdr, int unsigned msg);
    return hdr + msg + PARITY_BITS;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous level into the clk domain.
// Ports:
//   i_clk  system clock
//   i_rst  synchronous active-high reset, loads RESET_VALUE into both flops
//   i_d    asynchronous input
//   o_q    synchronized output
module sync_2ff #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= RESET_VALUE;
      r_sync <= RESET_VALUE;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/spi_frame_rx.sv
// SPI frame receiver (target side). Shifts a MSB-first frame of header then
// message (plus optional trailing even-parity bit) in from a far-end initiator,
// and presents completed frames on a single-entry valid/ready output buffer.
// Configuration macro: SPI_RX_PARITY_EN enables the trailing parity bit check.
// Ports:
//   clk_in          system clock, all logic on rising edge
//   rst_in          synchronous active-high reset
//   rx_data_in      serial data (async)
//   rx_sel_in       slave select, active low (async)
//   rx_clk_in       serial clock, idle low (async)
//   rx_key_req_in   key request level (async)
//   rx_ready_in     downstream ready
//   rx_valid_out    held frame available
//   rx_header_out   header of held frame
//   rx_message_out  message of held frame
//   rx_key_req_out  one-cycle pulse per key request rising edge
//   rx_error_out    one-cycle pulse per discarded frame
module spi_frame_rx
  import abae_spi_pkg::*;
#(
  parameter int unsigned MESSAGE_SIZE = MESSAGE_SIZE_DEF,
  parameter int unsigned HEADER_SIZE  = HEADER_SIZE_DEF
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rx_data_in,
  input  logic                    rx_sel_in,
  input  logic                    rx_clk_in,
  input  logic                    rx_key_req_in,
  input  logic                    rx_ready_in,
  output logic                    rx_valid_out,
  output logic [HEADER_SIZE-1:0]  rx_header_out,
  output logic [MESSAGE_SIZE-1:0] rx_message_out,
  output logic                    rx_key_req_out,
  output logic                    rx_error_out
);

  localparam int unsigned FB = frame_bits(HEADER_SIZE, MESSAGE_SIZE);
  localparam int unsigned CW = $clog2(FB + 1);

  // Synchronized inputs
  logic w_data_s;
  logic w_sel_s;
  logic w_sclk_s;
  logic w_key_s;

  sync_2ff #(.RESET_VALUE(1'b0)) u_sync_data (
    .i_clk (clk_in),
    .i_rst (rst_in),
    .i_d   (rx_data_in),
    .o_q   (w_data_s)
  );

  sync_2ff #(.RESET_VALUE(1'b1)) u_sync_sel (
    .i_clk (clk_in),
    .i_rst (rst_in),
    .i_d   (rx_sel_in),
    .o_q   (w_sel_s)
  );

  sync_2ff #(.RESET_VALUE(1'b0)) u_sync_sclk (
    .i_clk (clk_in),
    .i_rst (rst_in),
    .i_d   (rx_clk_in),
    .o_q   (w_sclk_s)
  );

  sync_2ff #(.RESET_VALUE(1'b0)) u_sync_key (
    .i_clk (clk_in),
    .i_rst (rst_in),
    .i_d   (rx_key_req_in),
    .o_q   (w_key_s)
  );

  // State
  spi_state_e              r_state;
  spi_state_e              w_state_next;
  logic [CW-1:0]           r_cnt;
  logic [CW-1:0]           w_cnt_next;
  logic [FB-1:0]           r_shreg;
  logic [FB-1:0]           w_shreg_next;
  logic                    r_sclk_prev;
  logic                    r_key_prev;
  logic [1:0]              r_flush;
  logic                    r_armed;
  logic                    r_valid;
  logic                    w_valid_next;
  logic [HEADER_SIZE-1:0]  r_header;
  logic [HEADER_SIZE-1:0]  w_header_next;
  logic [MESSAGE_SIZE-1:0] r_message;
  logic [MESSAGE_SIZE-1:0] w_message_next;
  logic                    r_err;
  logic                    w_err_next;
  logic                    r_key_pulse;

  logic w_sclk_rise;
  logic w_full;
  logic w_hs;
  logic w_commit;
  logic w_abort;
  logic w_load;
  logic w_parity_ok;

  assign w_sclk_rise = w_sclk_s & ~r_sclk_prev;
  assign w_full      = (r_cnt == CW'(FB));
  assign w_hs        = r_valid & rx_ready_in;

`ifdef SPI_RX_PARITY_EN
  // Even parity: XOR across header, message and parity bit must be zero.
  assign w_parity_ok = ~(^r_shreg);
`else
  assign w_parity_ok = 1'b1;
`endif

  // Sel synchronizer resets to "deselected", so sel reads high for two cycles
  // after reset even if the line is low. r_armed only sets once the
  // synchronizer has flushed and sel is genuinely high, so a frame cut by
  // reset is never resumed mid-stream.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_flush <= 2'b00;
      r_armed <= 1'b0;
    end else begin
      r_flush <= {r_flush[0], 1'b1};
      if (r_flush[1] && w_sel_s) begin
        r_armed <= 1'b1;
      end
    end
  end

  // FSM next state and shift datapath
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_shreg_next = r_shreg;
    w_commit     = 1'b0;
    w_abort      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (r_armed && !w_sel_s) begin
          w_state_next = StShift;
          w_cnt_next   = '0;
          w_shreg_next = '0;
        end
      end
      StShift: begin
        if (w_full) begin
          w_commit     = 1'b1;
          w_state_next = StWaitDeselect;
        end else if (w_sel_s) begin
          w_abort      = 1'b1;
          w_state_next = StIdle;
        end else if (w_sclk_rise) begin
          w_shreg_next = {r_shreg[FB-2:0], w_data_s};
          w_cnt_next   = r_cnt + CW'(1);
        end
      end
      StWaitDeselect: begin
        if (w_sel_s) begin
          w_state_next = StIdle;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // Output buffer: a commit loads only into an empty buffer or one being
  // drained in the same cycle; anything else is reported as an error.
  always_comb begin
    w_valid_next   = r_valid;
    w_header_next  = r_header;
    w_message_next = r_message;
    w_load         = w_commit & w_parity_ok & (~r_valid | w_hs);
    if (w_load) begin
      w_valid_next   = 1'b1;
      w_header_next  = r_shreg[FB-1 -: HEADER_SIZE];
      w_message_next = r_shreg[PARITY_BITS +: MESSAGE_SIZE];
    end else if (w_hs) begin
      w_valid_next = 1'b0;
    end
    w_err_next = w_abort | (w_commit & ~w_load);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_shreg     <= '0;
      r_sclk_prev <= 1'b0;
      r_key_prev  <= 1'b0;
      r_valid     <= 1'b0;
      r_header    <= '0;
      r_message   <= '0;
      r_err       <= 1'b0;
      r_key_pulse <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_shreg     <= w_shreg_next;
      r_sclk_prev <= w_sclk_s;
      r_key_prev  <= w_key_s;
      r_valid     <= w_valid_next;
      r_header    <= w_header_next;
      r_message   <= w_message_next;
      r_err       <= w_err_next;
      r_key_pulse <= w_key_s & ~r_key_prev;
    end
  end

  assign rx_valid_out   = r_valid;
  assign rx_header_out  = r_header;
  assign rx_message_out = r_message;
  assign rx_key_req_out = r_key_pulse;
  assign rx_error_out   = r_err;

endmodule
